// File: rtl/range_bn_stat_pkg.sv
// rtl/range_bn_stat_pkg.sv - shared widths, init constants and helpers for range_bn_stat
package range_bn_pkg;

  // The exchanged accumulator view is sized for the widest supported channel;
  // each channel fills the low bits and sign-extends max/min/sum.
  localparam int ACC_DW = 32;
  localparam int ACC_AW = 16;
  localparam int ACC_SW = ACC_DW + ACC_AW;

  typedef struct packed {
    logic [ACC_AW-1:0] cnt;
    logic [ACC_DW-1:0] max;
    logic [ACC_DW-1:0] min;
    logic [ACC_SW-1:0] sum;
  } acc_t;

  function automatic int sum_w(input int dw, input int aw);
    return dw + aw;
  endfunction

  function automatic logic [63:0] max_init(input int w);
    return 64'(1) << (w - 1);
  endfunction

  function automatic logic [63:0] min_init(input int w);
    return (64'(1) << (w - 1)) - 64'(1);
  endfunction

  function automatic logic [63:0] sat_pos(input logic [63:0] v, input int w);
    logic [63:0] lim;
    lim = min_init(w);
    return (v > lim) ? lim : v;
  endfunction

endpackage

// File: rtl/range_bn_stat_if.sv
// rtl/range_bn_stat_if.sv - sample input and result output handshake bundle
interface range_bn_stat_if #(
  parameter int DATA_WIDTH = 16,
  parameter int CH_WIDTH   = 2
);
  logic                         in_valid;
  logic                         in_ready;
  logic signed [DATA_WIDTH-1:0] in_data;
  logic [CH_WIDTH-1:0]          in_ch;
  logic                         out_valid;
  logic                         out_ready;
  logic [CH_WIDTH-1:0]          out_ch;
  logic signed [DATA_WIDTH-1:0] avg_out;
  logic signed [DATA_WIDTH-1:0] stan_dev_out;

  modport master (
    output in_valid, in_data, in_ch, out_ready,
    input  in_ready, out_valid, out_ch, avg_out, stan_dev_out
  );

  modport slave (
    input  in_valid, in_data, in_ch, out_ready,
    output in_ready, out_valid, out_ch, avg_out, stan_dev_out
  );
endinterface

// File: rtl/range_bn_stat_ch_acc.sv
// rtl/range_bn_stat_ch_acc.sv - one channel's running max/min/sum and sample count
module range_bn_ch_acc
  import range_bn_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 6
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clear,
  input  logic                         upd,
  input  logic signed [DATA_WIDTH-1:0] data,
  output acc_t                         state
);
  localparam int SUM_W = sum_w(DATA_WIDTH, ADDR_WIDTH);
  localparam logic signed [DATA_WIDTH-1:0] MAX_INIT = DATA_WIDTH'(max_init(DATA_WIDTH));
  localparam logic signed [DATA_WIDTH-1:0] MIN_INIT = DATA_WIDTH'(min_init(DATA_WIDTH));

  logic [ADDR_WIDTH-1:0]        r_cnt;
  logic signed [DATA_WIDTH-1:0] r_max;
  logic signed [DATA_WIDTH-1:0] r_min;
  logic signed [SUM_W-1:0]      r_sum;

  // The completing sample restarts the channel; its result is captured upstream.
  always_ff @(posedge clk) begin
    if (rst || clear || (upd && (&r_cnt))) begin
      r_cnt <= '0;
      r_max <= MAX_INIT;
      r_min <= MIN_INIT;
      r_sum <= '0;
    end else if (upd) begin
      r_cnt <= r_cnt + ADDR_WIDTH'(1);
      if (data > r_max) r_max <= data;
      if (data < r_min) r_min <= data;
      r_sum <= r_sum + SUM_W'(data);
    end
  end

  assign state.cnt = ACC_AW'(r_cnt);
  assign state.max = ACC_DW'(r_max);
  assign state.min = ACC_DW'(r_min);
  assign state.sum = ACC_SW'(r_sum);

endmodule

// File: rtl/range_bn_stat.sv
// rtl/range_bn_stat.sv - multi-channel streaming mean / scaled-range std-dev engine
module range_bn_stat
  import range_bn_pkg::*;
#(
  parameter int DATA_WIDTH  = 16,
  parameter int MINI_BATCH  = 64,
  parameter int ADDR_WIDTH  = $clog2(MINI_BATCH),
  parameter int NUM_CH      = 4,
  parameter int CH_WIDTH    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  parameter int SCALE_NUM   = 4,
  parameter int SCALE_SHIFT = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear_in,
  range_bn_stat_if.slave bus
);
  localparam int SUM_W = sum_w(DATA_WIDTH, ADDR_WIDTH);

  acc_t                         w_acc [NUM_CH];
  acc_t                         w_sel;
  logic                         w_fire;
  logic                         w_ch_ok;
  logic                         w_upd;
  logic                         w_done;
  logic signed [DATA_WIDTH-1:0] w_cur_max;
  logic signed [DATA_WIDTH-1:0] w_cur_min;
  logic signed [SUM_W-1:0]      w_cur_sum;
  logic signed [DATA_WIDTH-1:0] w_nmax;
  logic signed [DATA_WIDTH-1:0] w_nmin;
  logic signed [SUM_W-1:0]      w_nsum;
  logic signed [DATA_WIDTH-1:0] w_avg;
  logic [DATA_WIDTH:0]          w_range;
  logic [63:0]                  w_std_full;
  logic signed [DATA_WIDTH-1:0] w_std;

  logic                         r_valid;
  logic [CH_WIDTH-1:0]          r_ch;
  logic signed [DATA_WIDTH-1:0] r_avg;
  logic signed [DATA_WIDTH-1:0] r_std;

  // Stalls whenever the result slot is blocked, even for non-completing samples.
  assign bus.in_ready = !rst && !(r_valid && !bus.out_ready);
  assign w_fire       = bus.in_valid && bus.in_ready;
  assign w_ch_ok      = (32'(bus.in_ch) < NUM_CH);
  assign w_upd        = w_fire && !clear_in && w_ch_ok;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    range_bn_ch_acc #(
      .DATA_WIDTH(DATA_WIDTH),
      .ADDR_WIDTH(ADDR_WIDTH)
    ) u_acc (
      .clk  (clk),
      .rst  (rst),
      .clear(clear_in),
      .upd  (w_upd && (32'(bus.in_ch) == g)),
      .data (bus.in_data),
      .state(w_acc[g])
    );
  end

  assign w_sel     = w_ch_ok ? w_acc[bus.in_ch] : w_acc[0];
  assign w_cur_max = w_sel.max[DATA_WIDTH-1:0];
  assign w_cur_min = w_sel.min[DATA_WIDTH-1:0];
  assign w_cur_sum = w_sel.sum[SUM_W-1:0];

  assign w_nmax = (bus.in_data > w_cur_max) ? bus.in_data : w_cur_max;
  assign w_nmin = (bus.in_data < w_cur_min) ? bus.in_data : w_cur_min;
  assign w_nsum = w_cur_sum + SUM_W'(bus.in_data);
  assign w_done = w_upd && (&w_sel.cnt[ADDR_WIDTH-1:0]);

  // Floor-shifted mean always fits; range is non-negative at one extra bit.
  assign w_avg      = DATA_WIDTH'(w_nsum >>> ADDR_WIDTH);
  assign w_range    = {w_nmax[DATA_WIDTH-1], w_nmax} - {w_nmin[DATA_WIDTH-1], w_nmin};
  assign w_std_full = (64'(w_range) * 64'(SCALE_NUM)) >> SCALE_SHIFT;
  assign w_std      = DATA_WIDTH'(sat_pos(w_std_full, DATA_WIDTH));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_ch    <= '0;
      r_avg   <= '0;
      r_std   <= '0;
    end else if (w_done) begin
      r_valid <= 1'b1;
      r_ch    <= bus.in_ch;
      r_avg   <= w_avg;
      r_std   <= w_std;
    end else if (bus.out_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign bus.out_valid    = r_valid;
  assign bus.out_ch       = r_ch;
  assign bus.avg_out      = r_avg;
  assign bus.stan_dev_out = r_std;

endmodule

// File: tb/tb_range_bn_stat.sv
// tb/tb_range_bn_stat.sv - randomized and directed check of range_bn_stat against a sample-list model
module tb_range_bn_stat;
  localparam int DW  = 16;
  localparam int MB  = 4;
  localparam int NCH = 2;
  localparam int CHW = 1;

  typedef struct {
    int ch;
    int avg;
    int sd;
  } res_t;

  logic clk;
  logic rst;
  logic clear_in;

  range_bn_stat_if #(.DATA_WIDTH(DW), .CH_WIDTH(CHW)) bus ();

  range_bn_stat #(
    .DATA_WIDTH(DW),
    .MINI_BATCH(MB),
    .NUM_CH    (NCH)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .clear_in(clear_in),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_total = 0;
  int   n_bad   = 0;
  int   smp [NCH][$];
  res_t exp_q [$];
  res_t obs_q [$];
  logic rst_prev = 1'b0;

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Mean floors toward -inf; std is 4x range clipped to the positive maximum.
  function automatic res_t model_result(input int ch, input int s[$]);
    res_t r;
    int sum, mx, mn, sd;
    sum = 0;
    mx  = s[0];
    mn  = s[0];
    foreach (s[i]) begin
      sum += s[i];
      if (s[i] > mx) mx = s[i];
      if (s[i] < mn) mn = s[i];
    end
    sd = (mx - mn) * 4;
    if (sd > 32767) sd = 32767;
    r.ch  = ch;
    r.avg = (sum - (((sum % MB) + MB) % MB)) / MB;
    r.sd  = sd;
    return r;
  endfunction

  // Checks the state left by the previous edge, then models the coming edge.
  always @(negedge clk) begin
    int a, s;
    res_t o;
    chk("in_ready", bus.in_ready, !rst && !((exp_q.size() > 0) && !bus.out_ready));
    chk("out_valid", bus.out_valid, exp_q.size() > 0);
    a = bus.avg_out;
    s = bus.stan_dev_out;
    if (exp_q.size() > 0) begin
      chk("out_ch", bus.out_ch, exp_q[0].ch);
      chk("avg_out", a, exp_q[0].avg);
      chk("stan_dev_out", s, exp_q[0].sd);
    end else if (rst_prev) begin
      chk("rst_out_ch", bus.out_ch, 0);
      chk("rst_avg", a, 0);
      chk("rst_std", s, 0);
    end
    if (rst) begin
      exp_q.delete();
      for (int c = 0; c < NCH; c++) smp[c].delete();
    end else begin
      if (bus.out_valid && bus.out_ready && exp_q.size() > 0) begin
        o.ch  = bus.out_ch;
        o.avg = a;
        o.sd  = s;
        obs_q.push_back(o);
        void'(exp_q.pop_front());
      end
      if (bus.in_valid && bus.in_ready && !clear_in) begin
        smp[bus.in_ch].push_back(int'(bus.in_data));
        if (smp[bus.in_ch].size() == MB) begin
          exp_q.push_back(model_result(int'(bus.in_ch), smp[bus.in_ch]));
          smp[bus.in_ch].delete();
        end
      end
      if (clear_in) for (int c = 0; c < NCH; c++) smp[c].delete();
    end
    rst_prev = rst;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int ch, input int d);
    logic ok;
    bus.in_valid = 1'b1;
    bus.in_ch    = CHW'(ch);
    bus.in_data  = DW'(d);
    ok = 1'b0;
    for (int t = 0; t < 50 && !ok; t++) begin
      @(negedge clk);
      ok = bus.in_ready;
      step();
    end
    if (!ok) chk("send_timeout", 0, 1);
    bus.in_valid = 1'b0;
  endtask

  task automatic chk_res(input string tag, input int idx, input int ch, input int avg, input int sd);
    chk({tag, "_present"}, obs_q.size() > idx, 1);
    if (obs_q.size() > idx) begin
      chk({tag, "_ch"}, obs_q[idx].ch, ch);
      chk({tag, "_avg"}, obs_q[idx].avg, avg);
      chk({tag, "_std"}, obs_q[idx].sd, sd);
    end
  endtask

  initial begin
    rst           = 1'b1;
    clear_in      = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_ch     = '0;
    bus.in_data   = 16'sd7;
    bus.out_ready = 1'b1;
    repeat (3) step();
    rst          = 1'b0;
    bus.in_valid = 1'b0;
    step();

    send(0, 10); send(0, 20); send(0, -6); send(0, 8);
    repeat (3) step();
    chk_res("basic", 0, 0, 8, 104);

    send(1, 1); send(0, 5); send(1, 2); send(0, 5);
    send(1, 3); send(0, 5); send(1, 4); send(0, 5);
    repeat (3) step();
    chk_res("ilv_ch1", 1, 1, 2, 12);
    chk_res("ilv_ch0", 2, 0, 5, 0);

    bus.out_ready = 1'b0;
    send(1, 7); send(1, 7); send(1, 7); send(1, 7);
    bus.in_valid = 1'b1;
    bus.in_ch    = 1'b0;
    bus.in_data  = 16'sd3;
    repeat (5) begin
      @(negedge clk);
      chk("bp_in_ready", bus.in_ready, 0);
      step();
    end
    bus.out_ready = 1'b1;
    send(0, 3); send(0, 3); send(0, 3); send(0, 3);
    repeat (3) step();
    chk_res("bp_held", 3, 1, 7, 0);
    chk_res("bp_after", 4, 0, 3, 0);

    send(0, 32767); send(0, -32768); send(0, 32767); send(0, -32768);
    repeat (3) step();
    chk_res("sat", 5, 0, -1, 32767);

    send(0, 100); send(0, 100);
    clear_in     = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_ch    = 1'b0;
    bus.in_data  = 16'sd50;
    step();
    clear_in     = 1'b0;
    bus.in_valid = 1'b0;
    send(0, 1); send(0, 1); send(0, 1); send(0, 1);
    repeat (3) step();
    chk_res("clear", 6, 0, 1, 0);
    chk("clear_one_result", obs_q.size(), 7);

    send(0, 9);
    bus.out_ready = 1'b0;
    send(1, -4); send(1, -8); send(1, 0); send(1, 4);
    clear_in = 1'b1;
    step();
    clear_in = 1'b0;
    repeat (2) step();
    bus.out_ready = 1'b1;
    repeat (2) step();
    chk_res("clear_pending", 7, 1, -2, 48);
    send(0, 2); send(0, 2); send(0, 2); send(0, 2);
    repeat (3) step();
    chk_res("clear_partial", 8, 0, 2, 0);

    for (int cyc = 0; cyc < 600; cyc++) begin
      bus.in_valid  = ($urandom_range(3) != 0);
      bus.in_ch     = CHW'($urandom_range(NCH - 1));
      bus.in_data   = ($urandom_range(7) == 0) ? (($urandom_range(1) == 0) ? 16'sh7fff : 16'sh8000)
                                               : DW'($urandom);
      bus.out_ready = ($urandom_range(3) != 0);
      clear_in      = ($urandom_range(49) == 0);
      rst           = (cyc == 300 || cyc == 301);
      step();
    end
    rst           = 1'b0;
    clear_in      = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    repeat (5) step();
    chk("drain_empty", exp_q.size(), 0);
    chk("drain_valid", bus.out_valid, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
